// File: rtl/uart_baud_gen_pkg.sv
// ============================================================================
// Module      : uart_baud_gen_pkg
// Description : Shared constants and types for the UART baud-rate generator
//               and the UART CSR block that programs it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_baud_gen_pkg;

  // Field widths of the configuration as seen by the CSR block
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR_W  = 5;

  // Configuration active out of reset (326 clks per oversample tick, x16)
  localparam int DEF_DIV  = 326;
  localparam int DEF_FRAC = 0;
  localparam int DEF_OSR  = 16;

  // Smallest legal divisor and oversampling ratio; smaller offers are dropped
  localparam int MIN_DIV = 2;
  localparam int MIN_OSR = 4;

  // Configuration record as laid out in the CSR block
  typedef struct packed {
    logic [DIV_W-1:0]  div;
    logic [FRAC_W-1:0] frac;
    logic [OSR_W-1:0]  osr;
  } baud_cfg_t;

  // Occupancy of the staging register between the CSR port and the active set
  typedef enum logic [0:0] {
    SHADOW_EMPTY = 1'b0,
    SHADOW_FULL  = 1'b1
  } shadow_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen_frac_div.sv
// ============================================================================
// Module      : baud_frac_div
// Description : Fractional clock divider producing the oversample tick.
//               Each period lasts div + carry clocks, where carry is the
//               overflow of a phase accumulator advanced by frac per tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_frac_div #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clear,
  input  logic [DIV_W-1:0]  div,
  input  logic [FRAC_W-1:0] frac,
  output logic              os_tick,
  output logic              tick_nxt,
  output logic              wrap
);

  import uart_baud_gen_pkg::*;

  // The period needs one extra bit: div = 2^DIV_W-1 plus a carry is legal
  localparam int              PW        = DIV_W + 1;
  localparam logic [PW-1:0]   c_per_one = PW'(1);

  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic              r_tick;

  logic [PW-1:0]     w_period;
  logic [PW-1:0]     w_last_cnt;
  logic [PW-1:0]     w_cnt_inc;
  logic              w_at_last;
  logic [FRAC_W:0]   w_acc_sum;

  assign w_period   = {1'b0, div} + {{DIV_W{1'b0}}, r_carry};
  assign w_last_cnt = w_period - c_per_one;
  assign w_cnt_inc  = {1'b0, r_cnt} + c_per_one;
  assign w_at_last  = ({1'b0, r_cnt} == w_last_cnt);
  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, frac};

  // The tick flop is loaded one cycle ahead so it is high exactly while
  // cnt sits on period-1; a period of at least 2 means the cycle right
  // after a wrap can never be a tick cycle.
  assign tick_nxt = en & ~clear & ~w_at_last & (w_cnt_inc == w_last_cnt);
  assign wrap     = en & ~clear & w_at_last;
  assign os_tick  = r_tick;

  // Period counter, phase accumulator and registered oversample tick
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_tick  <= 1'b0;
    end else if (clear) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_tick  <= 1'b0;
    end else if (en) begin
      r_tick <= tick_nxt;
      if (w_at_last) begin
        r_cnt              <= '0;
        {r_carry, r_acc}   <= w_acc_sum;
      end else begin
        r_cnt <= w_cnt_inc[DIV_W-1:0];
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module      : uart_baud_gen
// Description : Runtime-programmable UART baud-rate generator. Produces the
//               oversample tick from a fractional divisor plus bit-rate and
//               mid-bit ticks from a programmable oversampling ratio. New
//               configurations are staged and applied on a bit boundary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR_W    = 5,
  parameter int DEF_DIV  = uart_baud_gen_pkg::DEF_DIV,
  parameter int DEF_FRAC = uart_baud_gen_pkg::DEF_FRAC,
  parameter int DEF_OSR  = uart_baud_gen_pkg::DEF_OSR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic [OSR_W-1:0]  cfg_osr,
  output logic              cfg_err,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  import uart_baud_gen_pkg::*;

  localparam logic [DIV_W-1:0]  c_def_div  = DIV_W'(DEF_DIV);
  localparam logic [FRAC_W-1:0] c_def_frac = FRAC_W'(DEF_FRAC);
  localparam logic [OSR_W-1:0]  c_def_osr  = OSR_W'(DEF_OSR);
  localparam logic [DIV_W-1:0]  c_min_div  = DIV_W'(MIN_DIV);
  localparam logic [OSR_W-1:0]  c_min_osr  = OSR_W'(MIN_OSR);
  localparam logic [OSR_W-1:0]  c_osr_one  = OSR_W'(1);

  // Active configuration driving the dividers
  logic [DIV_W-1:0]  r_act_div;
  logic [FRAC_W-1:0] r_act_frac;
  logic [OSR_W-1:0]  r_act_osr;

  // Staged configuration waiting for a bit boundary
  logic [DIV_W-1:0]  r_shd_div;
  logic [FRAC_W-1:0] r_shd_frac;
  logic [OSR_W-1:0]  r_shd_osr;
  shadow_state_t     r_shd_state;

  logic              r_cfg_ready;
  logic              r_cfg_err;
  logic [OSR_W-1:0]  r_os_cnt;
  logic              r_bit_tick;
  logic              r_mid_tick;

  logic              w_take;
  logic              w_legal;
  logic              w_apply;
  logic              w_restart;
  logic              w_clear;
  logic              w_os_tick_nxt;
  logic              w_os_wrap;
  logic [OSR_W-1:0]  w_osr_last;
  logic [OSR_W-1:0]  w_osr_mid;

  assign w_take    = cfg_valid & r_cfg_ready;
  assign w_legal   = (cfg_div >= c_min_div) & (cfg_osr >= c_min_osr);
  // While running, a staged config only lands at the end of a bit so the
  // receiver never sees a bit stretched or shortened by a rate change.
  assign w_apply   = (r_shd_state == SHADOW_FULL) & (~en | r_bit_tick);
  assign w_restart = restart & en;
  assign w_clear   = w_restart | w_apply;

  assign w_osr_last = r_act_osr - c_osr_one;
  assign w_osr_mid  = (r_act_osr >> 1) - c_osr_one;

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign bit_tick  = r_bit_tick;
  assign mid_tick  = r_mid_tick;

  baud_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .clear    (w_clear),
    .div      (r_act_div),
    .frac     (r_act_frac),
    .os_tick  (os_tick),
    .tick_nxt (w_os_tick_nxt),
    .wrap     (w_os_wrap)
  );

  // Oversample counter; advances when the oversample period rolls over
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_os_cnt <= '0;
    end else if (w_clear) begin
      r_os_cnt <= '0;
    end else if (w_os_wrap) begin
      r_os_cnt <= (r_os_cnt == w_osr_last) ? '0 : r_os_cnt + c_osr_one;
    end
  end

  // Bit and mid-bit ticks, registered alongside the oversample tick
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
    end else begin
      r_bit_tick <= w_os_tick_nxt & (r_os_cnt == w_osr_last);
      r_mid_tick <= w_os_tick_nxt & (r_os_cnt == w_osr_mid);
    end
  end

  // Config handshake: validate, stage in the shadow, then apply
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shd_state <= SHADOW_EMPTY;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_act_div   <= c_def_div;
      r_act_frac  <= c_def_frac;
      r_act_osr   <= c_def_osr;
      r_shd_div   <= c_def_div;
      r_shd_frac  <= c_def_frac;
      r_shd_osr   <= c_def_osr;
    end else begin
      r_cfg_err <= w_take & ~w_legal;
      case (r_shd_state)
        SHADOW_EMPTY: begin
          if (w_take && w_legal) begin
            r_shd_div   <= cfg_div;
            r_shd_frac  <= cfg_frac;
            r_shd_osr   <= cfg_osr;
            r_shd_state <= SHADOW_FULL;
            r_cfg_ready <= 1'b0;
          end
        end
        SHADOW_FULL: begin
          if (w_apply) begin
            r_act_div   <= r_shd_div;
            r_act_frac  <= r_shd_frac;
            r_act_osr   <= r_shd_osr;
            r_shd_state <= SHADOW_EMPTY;
            r_cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_shd_state <= SHADOW_EMPTY;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Runtime-programmable baud-rate generator for the UART TX/RX datapaths. It replaces the fixed-divisor tick counters. It produces an oversample tick (os_tick) from an integer+fractional clock divisor. It also produces bit-rate and mid-bit ticks by dividing os_tick by a programmable oversampling ratio (OSR). New configurations are staged through a valid/ready handshake and applied glitch-free on a bit boundary. A restart input realigns the phase to an RX start-bit edge.

Parameters:
DIV_W, 16, width of integer divisor (clk cycles per os_tick)
FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle)
OSR_W, 5, width of oversampling ratio field
DEF_DIV, 326, reset value of active integer divisor
DEF_FRAC, 0, reset value of active fractional divisor
DEF_OSR, 16, reset value of active OSR

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
en  in  1  generator enable; 0 = counters held, no ticks
restart  in  1  single-cycle pulse; realign phase (RX start-bit detect)
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  generator can accept a configuration
cfg_div  in  DIV_W  integer divisor, legal >= 2
cfg_frac  in  FRAC_W  fractional divisor
cfg_osr  in  OSR_W  oversampling ratio, legal >= 4
cfg_err  out  1  one-cycle pulse: offered config was illegal and dropped
os_tick  out  1  one-cycle pulse at oversample rate
bit_tick  out  1  one-cycle pulse once per OSR os_ticks
mid_tick  out  1  one-cycle pulse at mid-bit

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - cnt=0, acc=0, os_cnt=0.
  - Active config = DEF_DIV/DEF_FRAC/DEF_OSR; shadow empty.
  - os_tick=bit_tick=mid_tick=cfg_err=0; cfg_ready=1.
  - Reset overrides every other input, including mid-period and with a staged config pending.
- Fractional divider:
  - period = div + carry, where carry is latched at the previous os_tick.
  - cnt counts 0..period-1. os_tick=1 in the cycle cnt==period-1, and cnt then wraps to 0.
  - On each os_tick: {carry,acc} <= acc + frac (FRAC_W+1-bit sum).
  - Mean period = div + frac/2^FRAC_W.
- OSR divider:
  - os_cnt increments on each os_tick and wraps at osr-1.
  - bit_tick = os_tick & (os_cnt==osr-1).
  - mid_tick = os_tick & (os_cnt==(osr>>1)-1).
- All ticks are registered, asserted for exactly one cycle, and never overlap except bit_tick/mid_tick with os_tick.
- en=0:
  - cnt, acc and os_cnt freeze and all ticks are 0.
  - On en rising, counting resumes from the frozen values.
- restart (while en=1):
  - Next cycle: cnt=0, os_cnt=0, acc=0; no tick is emitted in the restart cycle.
  - The first os_tick follows after a full period.
  - restart has priority over a coincident tick.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - If cfg_div<2 or cfg_osr<4: drop the config, pulse cfg_err the next cycle, and keep cfg_ready=1.
  - Otherwise the legal config is written to shadow and cfg_ready drops to 0 the next cycle.
  - When en=1, the shadow is applied in the cycle after the next bit_tick.
  - When en=0, the shadow is applied on the next cycle.
  - Applying: load active config, clear cnt/os_cnt/acc, set cfg_ready=1.
  - A restart coincident with apply: both take effect (counters cleared, new config active).
  - Configs are never applied mid-bit while en=1.
- Widths:
  - cnt is DIV_W bits; the period add is DIV_W+1 bits (div = 2^DIV_W-1 with carry is legal).
  - os_cnt is OSR_W bits.

Decomposition:
- uart_pkg holds:
  - DEF_DIV/DEF_FRAC/DEF_OSR localparams.
  - MIN_DIV=2 and MIN_OSR=4.
  - typedef struct packed baud_cfg_t {div, frac, osr}, shared with the UART CSR block.
- One sub-module: baud_frac_div (cnt/acc/carry, en, clear, os_tick out).
- OSR counting, handshake and shadow logic stay in uart_baud_gen.

Test Plan:
- Reset, en=1, defaults -> os_tick every 326 clks, bit_tick every 5216 clks, mid_tick 8 os_ticks after each bit_tick boundary.
- Config div=325, frac=8, osr=16 with en=0 -> applied next cycle; os periods alternate 325/326; 16 consecutive periods total 5208 clks.
- en=1, config div=100, osr=8 offered mid-bit -> cfg_ready=0 until the cycle after the next bit_tick; the old rate holds up to it; afterwards os_tick every 100 clks and bit_tick every 800 clks.
- cfg_div=1 or cfg_osr=3 offered -> cfg_err pulse one cycle later; active rate unchanged; cfg_ready stays 1.
- restart pulse at cnt=200 of a 326 period -> no tick that period; next os_tick exactly 326 clks after restart; bit_tick 16 os_ticks later.
- reset_n low mid-period with a shadow pending -> all outputs 0, cfg_ready=1, defaults active, shadow discarded; en low for 1000 clks -> no ticks and counters resume unchanged.
